// File: rtl/mc_pkg.sv
// mc_pkg: shared pixel type, scheduler states and tap count for the six-tap half-pel path
package mc_pkg;
    localparam int SIXTAP_NTAPS = 6;
    typedef logic [7:0] pix_t;
    typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} sixtap_state_t;
endpackage

// File: rtl/sixtap_delay_line.sv
// sixtap_delay_line: FILT_LAT-stage shift of {issue, last} tracking results inside the filter
module sixtap_delay_line #(
    parameter int FILT_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_issue,
    input  logic i_last,
    output logic o_valid,
    output logic o_last,
    output logic o_busy
);
    logic [FILT_LAT-1:0] r_vld;
    logic [FILT_LAT-1:0] r_lst;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_lst <= '0;
        end else begin
            r_vld <= (r_vld << 1) | FILT_LAT'(i_issue);
            r_lst <= (r_lst << 1) | FILT_LAT'(i_issue & i_last);
        end
    end
    assign o_valid = r_vld[FILT_LAT-1];
    assign o_last  = r_lst[FILT_LAT-1] & o_valid;
    assign o_busy  = |r_vld;
endmodule

// File: rtl/sixtap_row_sched.sv
// sixtap_row_sched: six-tap half-pel row sequencer; SIXTAP_PERF_CNT_EN adds the o_stall_cnt counter
module sixtap_row_sched import mc_pkg::*; #(
    parameter int ROW_W    = 16,
    parameter int ROWS     = 16,
    parameter int FILT_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    input  pix_t        i_pix_in,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    output pix_t        o_tap_a,
    output pix_t        o_tap_b,
    output pix_t        o_tap_c,
    output pix_t        o_tap_d,
    output pix_t        o_tap_e,
    output pix_t        o_tap_f,
    input  pix_t        i_half_in,
    output pix_t        o_half_out,
    output logic        o_half_valid,
    output logic        o_half_last
`ifdef SIXTAP_PERF_CNT_EN
    ,
    output logic [15:0] o_stall_cnt
`endif
);
    localparam int CW = $clog2(ROW_W + 6);
    localparam int RW = $clog2(ROWS + 1);
    sixtap_state_t r_state, w_next;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    pix_t          r_win [SIXTAP_NTAPS];
    logic          r_issue, r_last;
    logic          w_xfer, w_accept, w_fill_end, w_row_end, w_dl_busy, w_empty;
    assign w_xfer     = i_pix_valid & o_pix_ready;
    assign w_accept   = (r_state == IDLE) & i_start;
    assign w_fill_end = (r_state == FILL) & w_xfer & (r_col == CW'(4));
    assign w_row_end  = (r_state == RUN) & w_xfer & (r_col == CW'(ROW_W + 4));
    assign w_empty    = ~r_issue & ~w_dl_busy;
    always_comb begin
        w_next      = r_state;
        o_busy      = (r_state == FILL) || (r_state == RUN) || (r_state == DRAIN);
        o_done      = r_state == DONE;
        o_pix_ready = (r_state == FILL) || (r_state == RUN);
        case (r_state)
            IDLE:    w_next = i_start ? FILL : IDLE;
            FILL:    w_next = w_fill_end ? RUN : FILL;
            RUN:     w_next = w_row_end ? DRAIN : RUN;
            DRAIN:   w_next = !w_empty ? DRAIN : (r_row == RW'(ROWS - 1)) ? DONE : FILL;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_issue <= 1'b0;
            r_last  <= 1'b0;
            for (int i = 0; i < SIXTAP_NTAPS; i++) r_win[i] <= '0;
        end else begin
            r_state <= w_next;
            r_issue <= (r_state == RUN) & w_xfer;
            r_last  <= w_row_end;
            if (w_accept) begin
                r_col <= '0;
                r_row <= '0;
            end
            if (w_xfer) begin
                r_col <= r_col + 1'b1;
                for (int i = 0; i < SIXTAP_NTAPS - 1; i++) r_win[i] <= r_win[i+1];
                r_win[SIXTAP_NTAPS-1] <= i_pix_in;
            end
            // row finished draining: the next row starts from an empty window
            if ((r_state == DRAIN) && w_empty) begin
                r_row <= r_row + 1'b1;
                r_col <= '0;
                for (int i = 0; i < SIXTAP_NTAPS; i++) r_win[i] <= '0;
            end
        end
    end
    sixtap_delay_line #(.FILT_LAT(FILT_LAT)) u_dl (
        .clk     (clk),
        .rst     (rst),
        .i_issue (r_issue),
        .i_last  (r_last),
        .o_valid (o_half_valid),
        .o_last  (o_half_last),
        .o_busy  (w_dl_busy)
    );
    assign o_tap_a    = r_win[0];
    assign o_tap_b    = r_win[1];
    assign o_tap_c    = r_win[2];
    assign o_tap_d    = r_win[3];
    assign o_tap_e    = r_win[4];
    assign o_tap_f    = r_win[5];
    assign o_half_out = i_half_in;
`ifdef SIXTAP_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    always_ff @(posedge clk) begin
        if (rst || w_accept) r_stall_cnt <= '0;
        else if (o_pix_ready && !i_pix_valid && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
    assign o_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_sixtap_row_sched.sv
// tb_sixtap_row_sched: directed bench with an XOR filter stub of latency 2 (ROW_W=4, ROWS=2)
module tb_sixtap_row_sched;
    import mc_pkg::*;
    logic clk = 1'b0;
    logic rst, start, pix_valid;
    pix_t pix_in, half_in;
    logic busy, done, pix_ready, half_valid, half_last;
    pix_t tap_a, tap_b, tap_c, tap_d, tap_e, tap_f, half_out;
    logic [15:0] stall_cnt;
    logic [15:0] stall_at_done;
    int checks = 0, errors = 0, done_cnt = 0, cyc = 10;
    logic [47:0] tap_hist [64];
    logic [47:0] q_taps [$];
    pix_t        q_val [$];
    logic        q_last [$];
    int          q_cyc [$];
    pix_t        r_s1, r_s2;
    always #5 clk = ~clk;
    sixtap_row_sched #(.ROW_W(4), .ROWS(2), .FILT_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .o_busy       (busy),
        .o_done       (done),
        .i_pix_in     (pix_in),
        .i_pix_valid  (pix_valid),
        .o_pix_ready  (pix_ready),
        .o_tap_a      (tap_a),
        .o_tap_b      (tap_b),
        .o_tap_c      (tap_c),
        .o_tap_d      (tap_d),
        .o_tap_e      (tap_e),
        .o_tap_f      (tap_f),
        .i_half_in    (half_in),
        .o_half_out   (half_out),
        .o_half_valid (half_valid),
        .o_half_last  (half_last)
`ifdef SIXTAP_PERF_CNT_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );
`ifndef SIXTAP_PERF_CNT_EN
    assign stall_cnt = '0;
`endif
    always @(posedge clk) begin
        r_s1 <= tap_a ^ tap_f;
        r_s2 <= r_s1;
        cyc  <= cyc + 1;
    end
    assign half_in = r_s2;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        tap_hist[cyc % 64] = {tap_a, tap_b, tap_c, tap_d, tap_e, tap_f};
        if (half_valid === 1'b1) begin
            q_val.push_back(half_out);
            q_last.push_back(half_last);
            q_cyc.push_back(cyc);
            q_taps.push_back(tap_hist[(cyc - 2) % 64]);
        end
        if (half_last === 1'b1) chk("pix_ready_in_drain", 64'(pix_ready), 0);
        if (done === 1'b1) begin
            done_cnt++;
            stall_at_done = stall_cnt;
            chk("busy_at_done", 64'(busy), 0);
        end
    end
    task automatic feed(input int v);
        int n = 0;
        pix_in    = pix_t'(v);
        pix_valid = 1'b1;
        while (pix_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pix_ready_wait", 64'(pix_ready), 1);
        @(negedge clk);
    endtask
    task automatic clear_q();
        q_val.delete();
        q_last.delete();
        q_cyc.delete();
        q_taps.delete();
        done_cnt = 0;
    endtask
    task automatic run_block(input int stall_pix, input bit mid_start);
        int n = 0;
        clear_q();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 9; k++) begin
                if (mid_start && r == 0 && k == 7) start = 1'b1;
                feed(r * 20 + 1 + k);
                start = 1'b0;
                if (r == 0 && k + 1 == stall_pix) begin
                    pix_valid = 1'b0;
                    repeat (3) @(negedge clk);
                end
            end
        end
        pix_valid = 1'b0;
        while (done_cnt == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("done_count", 64'(done_cnt), 1);
        chk("busy_after_done", 64'(busy), 0);
        chk("n_results", 64'(q_val.size()), 8);
        for (int i = 0; i < q_val.size() && i < 8; i++) begin
            int b = (i < 4 ? 1 : 21) + i % 4;
            logic [47:0] t = '0;
            for (int j = 0; j < 6; j++) t = {t[39:0], 8'(b + j)};
            chk($sformatf("half_out[%0d]", i), 64'(q_val[i]), 64'(b ^ (b + 5)));
            chk($sformatf("taps_lat2[%0d]", i), 64'(q_taps[i]), 64'(t));
            chk($sformatf("half_last[%0d]", i), 64'(q_last[i]), 64'(i % 4 == 3));
            if (i % 4 != 0)
                chk($sformatf("gap[%0d]", i), 64'(q_cyc[i] - q_cyc[i-1]),
                    (stall_pix > 0 && i == stall_pix - 5) ? 64'd4 : 64'd1);
        end
`ifdef SIXTAP_PERF_CNT_EN
        chk("stall_cnt_at_done", 64'(stall_at_done), stall_pix > 0 ? 64'd3 : 64'd0);
`endif
    endtask
    initial begin
        rst = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        pix_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_pix_ready", 64'(pix_ready), 0);
        chk("rst_half_valid", 64'(half_valid), 0);
        chk("rst_half_last", 64'(half_last), 0);
        chk("rst_taps", 64'({tap_a, tap_b, tap_c, tap_d, tap_e, tap_f}), 0);
        rst = 1'b0;
        @(negedge clk);
        run_block(0, 1'b0);
        run_block(6, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) feed(1 + k);
        pix_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_pix_ready", 64'(pix_ready), 0);
        chk("midrst_half_valid", 64'(half_valid), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_no_results", 64'(half_valid), 0);
        run_block(0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
